// File: rtl/ro_puf_chall_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ro_puf_pkg
// Purpose  : Shared FSM state encoding, default constants and a small helper
//            for the RO-PUF challenge sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ro_puf_pkg;

  // Sequencer states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COUNT   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_WRITE   = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  localparam int DEF_CHALL_W    = 8;
  localparam int DEF_WIN_CYC    = 1024;
  localparam int DEF_SETTLE_CYC = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ro_puf_chall_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : ro_puf_chall_seq_if
// Purpose  : Control/status and RAM write bundle of the RO-PUF sequencer.
//            vote_unstable_o exists only when RO_PUF_MAJORITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface ro_puf_chall_seq_if #(
  parameter int NUM_BITS = 32,
  parameter int CHALL_W  = 8,
  parameter int ADDR_W   = 5
);
  logic                start_i;
  logic [CHALL_W-1:0]  chall_base_i;
  logic [ADDR_W-1:0]   ram_addr_i;
  logic                cmp_bit_i;
  logic                busy_o;
  logic                done_o;
  logic                roen_o;
  logic                cnt_clr_o;
  logic                cnt_en_o;
  logic [CHALL_W-1:0]  chall_o;
  logic [NUM_BITS-1:0] resp_o;
  logic [ADDR_W-1:0]   wr_addr_o;
  logic [NUM_BITS-1:0] wr_data_o;
  logic                wr_en_o;
`ifdef RO_PUF_MAJORITY_EN
  logic                vote_unstable_o;
`endif

  // Controller / testbench side
  modport master (
`ifdef RO_PUF_MAJORITY_EN
    input  vote_unstable_o,
`endif
    output start_i, chall_base_i, ram_addr_i, cmp_bit_i,
    input  busy_o, done_o, roen_o, cnt_clr_o, cnt_en_o, chall_o,
    input  resp_o, wr_addr_o, wr_data_o, wr_en_o
  );

  // Sequencer side
  modport slave (
`ifdef RO_PUF_MAJORITY_EN
    output vote_unstable_o,
`endif
    input  start_i, chall_base_i, ram_addr_i, cmp_bit_i,
    output busy_o, done_o, roen_o, cnt_clr_o, cnt_en_o, chall_o,
    output resp_o, wr_addr_o, wr_data_o, wr_en_o
  );
endinterface
`default_nettype wire

// File: rtl/ro_puf_chall_seq_win_timer.sv
`default_nettype none
// ============================================================================
// Module   : ro_puf_win_timer
// Purpose  : Loadable down-counter. go_i loads a period of load_i cycles;
//            expire_o is high in the last cycle of that period. A go_i in the
//            expire cycle starts the next period back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module ro_puf_win_timer #(
  parameter int TMR_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             go_i,
  input  wire logic [TMR_W-1:0] load_i,
  output logic                  expire_o
);

  logic [TMR_W-1:0] cnt_q;
  logic             active_q;

  // Count down from load-1 to zero, then go idle until reloaded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (go_i) begin
      cnt_q    <= load_i - TMR_W'(1);
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) active_q <= 1'b0;
      else             cnt_q    <= cnt_q - TMR_W'(1);
    end
  end

  assign expire_o = active_q && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/ro_puf_chall_seq.sv
`default_nettype none
// ============================================================================
// Module   : ro_puf_chall_seq
// Purpose  : Walks NUM_BITS consecutive challenges from chall_base, runs one
//            clear/settle/count/capture evaluation per challenge, packs the
//            comparator bits LSB first and writes the word to RAM.
//            Optional macro RO_PUF_MAJORITY_EN: three evaluations per
//            challenge with majority vote and a vote_unstable flag.
// Revision : 1.0 - initial release
// ============================================================================
module ro_puf_chall_seq
  import ro_puf_pkg::*;
#(
  parameter int NUM_BITS   = 32,
  parameter int CHALL_W    = DEF_CHALL_W,
  parameter int WIN_CYC    = DEF_WIN_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int ADDR_W     = 5
) (
  input wire logic          clk,
  input wire logic          rst,
  ro_puf_chall_seq_if.slave bus
);

  localparam int TMR_W = $clog2(max_int(WIN_CYC, SETTLE_CYC)) + 1;
  localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC);
  localparam logic [TMR_W-1:0] WIN_LD    = TMR_W'(WIN_CYC);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [CHALL_W-1:0]  chall_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NUM_BITS-1:0] resp_q;

  logic             w_tmr_go;
  logic [TMR_W-1:0] w_tmr_load;
  logic             w_tmr_expire;
  logic             w_last_bit;
  logic             w_last_eval;
  logic             w_bit;

`ifdef RO_PUF_MAJORITY_EN
  logic [1:0] vote_cnt_q;
  logic [1:0] votes_q;
  logic       unstable_q;
  logic       w_split;

  assign w_last_eval = (vote_cnt_q == 2'd2);
  assign w_bit   = (votes_q[0] & votes_q[1]) | (votes_q[0] & bus.cmp_bit_i)
                 | (votes_q[1] & bus.cmp_bit_i);
  assign w_split = !((votes_q[0] == votes_q[1]) && (votes_q[1] == bus.cmp_bit_i));
  assign bus.vote_unstable_o = unstable_q;
`else
  assign w_last_eval = 1'b1;
  assign w_bit       = bus.cmp_bit_i;
`endif

  assign w_last_bit = (idx_q == IDX_W'(NUM_BITS - 1));

  ro_puf_win_timer #(.TMR_W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .go_i     (w_tmr_go),
    .load_i   (w_tmr_load),
    .expire_o (w_tmr_expire)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state, timer control and decoded outputs
  always_comb begin
    state_d       = state_q;
    w_tmr_go      = 1'b0;
    w_tmr_load    = '0;
    bus.busy_o    = (state_q != ST_IDLE);
    bus.done_o    = 1'b0;
    bus.roen_o    = 1'b0;
    bus.cnt_clr_o = 1'b0;
    bus.cnt_en_o  = 1'b0;
    bus.wr_en_o   = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start_i) state_d = ST_CLEAR;
      ST_CLEAR: begin
        bus.cnt_clr_o = 1'b1;
        w_tmr_go      = 1'b1;
        w_tmr_load    = SETTLE_LD;
        state_d       = ST_SETTLE;
      end
      ST_SETTLE: begin
        bus.roen_o = 1'b1;
        if (w_tmr_expire) begin
          w_tmr_go   = 1'b1;
          w_tmr_load = WIN_LD;
          state_d    = ST_COUNT;
        end
      end
      ST_COUNT: begin
        bus.roen_o   = 1'b1;
        bus.cnt_en_o = 1'b1;
        if (w_tmr_expire) state_d = ST_CAPTURE;
      end
      // Counts are frozen here; cnt_en dropped at the end of COUNT
      ST_CAPTURE: state_d = (w_last_eval && w_last_bit) ? ST_WRITE : ST_CLEAR;
      ST_WRITE: begin
        bus.wr_en_o = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        bus.done_o = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Run context: sample inputs at start, pack captured bits, step challenge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      chall_q <= '0;
      addr_q  <= '0;
      resp_q  <= '0;
`ifdef RO_PUF_MAJORITY_EN
      vote_cnt_q <= '0;
      votes_q    <= '0;
      unstable_q <= 1'b0;
`endif
    end else if (state_q == ST_IDLE && bus.start_i) begin
      idx_q   <= '0;
      chall_q <= bus.chall_base_i;
      addr_q  <= bus.ram_addr_i;
      resp_q  <= '0;
`ifdef RO_PUF_MAJORITY_EN
      vote_cnt_q <= '0;
      unstable_q <= 1'b0;
`endif
    end else if (state_q == ST_CAPTURE) begin
      if (w_last_eval) begin
        resp_q[idx_q] <= w_bit;
`ifdef RO_PUF_MAJORITY_EN
        unstable_q <= unstable_q | w_split;
        vote_cnt_q <= '0;
`endif
        if (!w_last_bit) begin
          idx_q   <= idx_q + IDX_W'(1);
          chall_q <= chall_q + CHALL_W'(1);
        end
      end else begin
`ifdef RO_PUF_MAJORITY_EN
        votes_q[vote_cnt_q[0]] <= bus.cmp_bit_i;
        vote_cnt_q             <= vote_cnt_q + 2'd1;
`endif
      end
    end
  end

  assign bus.chall_o   = chall_q;
  assign bus.resp_o    = resp_q;
  assign bus.wr_addr_o = addr_q;
  assign bus.wr_data_o = resp_q;

endmodule
`default_nettype wire

// File: tb/tb_ro_puf_chall_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ro_puf_chall_seq
// Purpose  : Directed self-checking bench for ro_puf_chall_seq with
//            NUM_BITS=4, WIN_CYC=8, SETTLE_CYC=2. Cycle 1 is the cycle in
//            which start is driven high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ro_puf_chall_seq;

  localparam int NB  = 4;
  localparam int WIN = 8;
  localparam int SET = 2;
`ifdef RO_PUF_MAJORITY_EN
  localparam int EV = 3;
`else
  localparam int EV = 1;
`endif
  localparam int LAT = 2 + NB * EV * (SET + WIN + 2) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] flip_mask = '0;
  logic [5:0]  eval_cnt;
  int          n_cmp  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ro_puf_chall_seq_if #(.NUM_BITS(NB), .CHALL_W(8), .ADDR_W(5)) bus ();

  ro_puf_chall_seq #(
    .NUM_BITS(NB), .CHALL_W(8), .WIN_CYC(WIN), .SETTLE_CYC(SET), .ADDR_W(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Comparator model: bit = chall[0], optionally inverted per evaluation
  always @(posedge clk or negedge rst) begin
    if (!rst)                              eval_cnt <= '0;
    else if (bus.start_i && !bus.busy_o)   eval_cnt <= '0;
    else if (bus.cnt_clr_o)                eval_cnt <= eval_cnt + 6'd1;
  end
  assign bus.cmp_bit_i = bus.chall_o[0] ^ flip_mask[eval_cnt];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full run; re1/re2 are cycles where a stray start is pulsed
  task automatic run_vec(input logic [7:0] base, input logic [4:0] addr,
                         input logic [63:0] fmask, input logic [3:0] exp_resp,
                         input logic exp_unst, input int re1, input int re2);
    int cyc, done_cyc, wr_cyc, n_done, n_wr, n_cnt, n_clr, chall_bad, k;
    logic [4:0] wa;
    logic [3:0] wd, rs;
    logic       un;
    done_cyc = 0; wr_cyc = 0; n_done = 0; n_wr = 0; n_cnt = 0; n_clr = 0;
    chall_bad = 0; wa = '0; wd = '0; rs = '0; un = 1'b0;
    flip_mask = fmask;
    @(negedge clk);
    check("idle_before_start", {63'd0, bus.busy_o}, 64'd0);
    bus.chall_base_i = base;
    bus.ram_addr_i   = addr;
    bus.start_i      = 1'b1;
    cyc = 1;
    while (cyc < LAT + 4) begin
      @(negedge clk);
      cyc++;
      bus.start_i = (cyc == re1) || (cyc == re2);
      if (bus.start_i) begin
        bus.chall_base_i = ~base;
        bus.ram_addr_i   = ~addr;
      end
      if (cyc == 2) check("busy_after_start", {63'd0, bus.busy_o}, 64'd1);
      if (bus.cnt_clr_o) n_clr++;
      if (bus.cnt_en_o) begin
        k = n_cnt / (WIN * EV);
        if (bus.chall_o !== 8'(int'(base) + k)) chall_bad++;
        n_cnt++;
      end
      if (bus.wr_en_o) begin
        n_wr++; wr_cyc = cyc; wa = bus.wr_addr_o; wd = bus.wr_data_o;
      end
      if (bus.done_o) begin
        n_done++; done_cyc = cyc; rs = bus.resp_o;
`ifdef RO_PUF_MAJORITY_EN
        un = bus.vote_unstable_o;
`endif
      end
    end
    bus.start_i = 1'b0;
    check("done_cycle", 64'(done_cyc), 64'(LAT));
    check("done_pulses", 64'(n_done), 64'd1);
    check("wr_en_cycle", 64'(wr_cyc), 64'(LAT - 1));
    check("wr_en_pulses", 64'(n_wr), 64'd1);
    check("wr_addr", {59'd0, wa}, {59'd0, addr});
    check("wr_data", {60'd0, wd}, {60'd0, exp_resp});
    check("resp_at_done", {60'd0, rs}, {60'd0, exp_resp});
    check("resp_held", {60'd0, bus.resp_o}, {60'd0, exp_resp});
    check("cnt_en_cycles", 64'(n_cnt), 64'(NB * EV * WIN));
    check("cnt_clr_pulses", 64'(n_clr), 64'(NB * EV));
    check("chall_during_count", 64'(chall_bad), 64'd0);
    check("chall_final", {56'd0, bus.chall_o}, {56'd0, 8'(base + 8'(NB - 1))});
    check("idle_after_done", {63'd0, bus.busy_o}, 64'd0);
`ifdef RO_PUF_MAJORITY_EN
    check("vote_unstable", {63'd0, un}, {63'd0, exp_unst});
`else
    if (exp_unst) check("vote_unstable_unexpected", 64'd1, 64'd0);
`endif
  endtask

  typedef struct {
    logic [7:0]  base;
    logic [4:0]  addr;
    logic [63:0] fmask;
    logic [3:0]  exp_resp;
    int          re1;
    int          re2;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int cyc, n_wr, cnt_start;
    // base, addr, comparator inversion, expected resp (bit k = (base+k)[0]^inv)
    vecs[0] = '{8'h69, 5'h0A, 64'h0,  4'b0101, 0,       0};
    vecs[1] = '{8'hFE, 5'h1F, 64'h0,  4'b1010, 5,       30};
    vecs[2] = '{8'h00, 5'h00, '1,     4'b0101, 0,       0};
    vecs[3] = '{8'h33, 5'h15, '1,     4'b1010, LAT - 1, LAT};

    bus.start_i      = 1'b1;
    bus.chall_base_i = 8'h5A;
    bus.ram_addr_i   = 5'h11;

    // Reset held with start asserted
    repeat (3) @(negedge clk);
    check("rst_busy",    {63'd0, bus.busy_o},    64'd0);
    check("rst_done",    {63'd0, bus.done_o},    64'd0);
    check("rst_roen",    {63'd0, bus.roen_o},    64'd0);
    check("rst_cnt_clr", {63'd0, bus.cnt_clr_o}, 64'd0);
    check("rst_cnt_en",  {63'd0, bus.cnt_en_o},  64'd0);
    check("rst_wr_en",   {63'd0, bus.wr_en_o},   64'd0);
    check("rst_chall",   {56'd0, bus.chall_o},   64'd0);
    check("rst_resp",    {60'd0, bus.resp_o},    64'd0);
    check("rst_wr_addr", {59'd0, bus.wr_addr_o}, 64'd0);
    bus.start_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {63'd0, bus.busy_o}, 64'd0);

    for (int i = 0; i < 4; i++)
      run_vec(vecs[i].base, vecs[i].addr, vecs[i].fmask, vecs[i].exp_resp,
              1'b0, vecs[i].re1, vecs[i].re2);

    // Reset during the counting window of bit 2
    cnt_start = 2 + 2 * EV * (SET + WIN + 2) + 1 + SET;
    flip_mask = '0;
    n_wr = 0;
    @(negedge clk);
    bus.chall_base_i = 8'h10;
    bus.ram_addr_i   = 5'h07;
    bus.start_i      = 1'b1;
    cyc = 1;
    while (cyc < cnt_start + 3) begin
      @(negedge clk);
      cyc++;
      bus.start_i = 1'b0;
      if (bus.wr_en_o) n_wr++;
    end
    check("mid_in_count", {62'd0, bus.roen_o, bus.cnt_en_o}, 64'd3);
    check("mid_partial_resp", {60'd0, bus.resp_o}, 64'h2);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_roen_cnt_en", {62'd0, bus.roen_o, bus.cnt_en_o}, 64'd0);
    check("mid_rst_resp", {60'd0, bus.resp_o}, 64'd0);
    check("mid_rst_busy", {63'd0, bus.busy_o}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      if (bus.wr_en_o) n_wr++;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.wr_en_o) n_wr++;
    end
    check("mid_rst_no_write", 64'(n_wr), 64'd0);
    run_vec(8'h10, 5'h07, 64'h0, 4'b1010, 1'b0, 0, 0);

`ifdef RO_PUF_MAJORITY_EN
    // Bit 0 votes 1,0,1 -> majority 1, word flagged unstable
    run_vec(8'h01, 5'h02, 64'h4, 4'b0101, 1'b1, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
